// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_pkg
//  Description : Shared bus widths, constant words and state encoding for the
//                instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

    localparam int c_inst_addr_w = 32;
    localparam int c_inst_w      = 32;

    typedef logic [c_inst_addr_w-1:0] inst_addr_t;
    typedef logic [c_inst_w-1:0]      inst_t;

    localparam inst_t      c_zero_word    = '0;
    localparam logic       c_chip_enable  = 1'b1;
    localparam logic       c_chip_disable = 1'b0;
    localparam inst_addr_t c_reset_pc     = 32'h0000_0000;
    localparam inst_addr_t c_pc_step      = 32'd4;

    // Fetch sequencer: idle for one cycle after reset, then fetching.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_t;

    // Word alignment test for a byte address.
    function automatic logic is_aligned(input inst_addr_t addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : if_fetch_pkg
`default_nettype wire

// File: rtl/if_fetch_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_pc_reg
//  Description : Program counter register with next-PC priority selection
//                (flush > hold > branch > sequential).
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_pc_reg
    import if_fetch_pkg::*;
#(
    parameter inst_addr_t RESET_PC = c_reset_pc
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  inst_addr_t new_pc,
    input  logic       hold,
    input  logic       branch_flag,
    input  inst_addr_t branch_target,
    output inst_addr_t pc
);

    inst_addr_t r_pc;
    inst_addr_t w_pc_next;

    // Next-PC priority mux; sequential increment wraps silently at 2^32.
    always_comb begin
        w_pc_next = r_pc + c_pc_step;
        if (flush) begin
            w_pc_next = new_pc;
        end else if (hold) begin
            w_pc_next = r_pc;
        end else if (branch_flag) begin
            w_pc_next = branch_target;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc = r_pc;

endmodule : if_fetch_pc_reg
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch
//  Description : Instruction fetch stage. Drives the instruction ROM from the
//                PC, pairs ROM data with the issuing PC, honours stall, flush,
//                branch (with delay slot) and reports misaligned fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int         REG_OUT  = 1,
    parameter inst_addr_t RESET_PC = c_reset_pc
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       flush,
    input  inst_addr_t new_pc,
    input  logic       branch_flag,
    input  inst_addr_t branch_target,
    output logic       rom_ce,
    output inst_addr_t rom_addr,
    input  inst_t      rom_inst,
    output inst_addr_t if_pc,
    output inst_t      if_inst,
    output logic       if_valid,
    output logic       if_adel
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    inst_addr_t w_pc;
    logic       w_fetching;
    logic       w_aligned;
    logic       w_issue;
    logic       w_hold;
    logic       w_adel_req;

    // Misaligned-fetch bookkeeping: report once, then stay quiet until flush.
    logic       r_adel_pend;
    logic       r_adel_seen;
    inst_addr_t r_resp_pc;

    logic       w_out_valid;
    logic       w_out_adel;
    inst_addr_t w_out_pc;
    inst_t      w_out_inst;

    // PC only moves when a request actually goes out (or on flush); an idle,
    // stalled or misaligned PC holds so the same address is retried/reported.
    if_fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .new_pc        (new_pc),
        .hold          (w_hold),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .pc            (w_pc)
    );

    // Next-state: leave IDLE on the first cycle out of reset, then stay.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  w_state_next = ST_FETCH;
            ST_FETCH: w_state_next = ST_FETCH;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_fetching = (r_state == ST_FETCH);
    assign w_aligned  = is_aligned(w_pc);
    assign w_issue    = w_fetching && !stall && w_aligned;
    assign w_hold     = stall || !w_issue;
    assign w_adel_req = w_fetching && !w_aligned && !r_adel_seen && !stall && !flush;

    assign rom_ce   = w_issue ? c_chip_enable : c_chip_disable;
    assign rom_addr = w_pc;

    // Misaligned reporting and the PC of the response being tracked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_adel_pend <= 1'b0;
            r_adel_seen <= 1'b0;
            r_resp_pc   <= '0;
        end else begin
            r_adel_pend <= w_adel_req;
            r_adel_seen <= flush ? 1'b0 : (r_adel_seen || w_adel_req);
            if (w_issue || w_adel_req) begin
                r_resp_pc <= w_pc;
            end
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            // A request issued this cycle returns data next cycle; flush or
            // reset in the issuing cycle kills it before it is presented.
            logic       r_pend;
            logic       r_last_valid;
            logic       r_last_adel;
            inst_addr_t r_last_pc;
            inst_t      r_last_inst;

            // Pending-response flag and copy of what was last presented.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pend       <= 1'b0;
                    r_last_valid <= 1'b0;
                    r_last_adel  <= 1'b0;
                    r_last_pc    <= '0;
                    r_last_inst  <= c_zero_word;
                end else begin
                    r_pend       <= w_issue && !flush;
                    r_last_valid <= w_out_valid;
                    r_last_adel  <= w_out_adel;
                    r_last_pc    <= w_out_pc;
                    r_last_inst  <= w_out_inst;
                end
            end

            // Output select: fresh response, misaligned report, stall hold.
            always_comb begin
                w_out_valid = 1'b0;
                w_out_adel  = 1'b0;
                w_out_pc    = '0;
                w_out_inst  = c_zero_word;
                if (r_pend) begin
                    w_out_valid = 1'b1;
                    w_out_pc    = r_resp_pc;
                    w_out_inst  = rom_inst;
                end else if (r_adel_pend) begin
                    w_out_valid = 1'b1;
                    w_out_adel  = 1'b1;
                    w_out_pc    = r_resp_pc;
                end else if (stall) begin
                    w_out_valid = r_last_valid;
                    w_out_adel  = r_last_adel;
                    w_out_pc    = r_last_pc;
                    w_out_inst  = r_last_inst;
                end
            end
        end else begin : g_comb_out
            // Combinational ROM: data belongs to the address driven now.
            always_comb begin
                w_out_valid = 1'b0;
                w_out_adel  = 1'b0;
                w_out_pc    = w_pc;
                w_out_inst  = c_zero_word;
                if (w_issue) begin
                    w_out_valid = 1'b1;
                    w_out_inst  = rom_inst;
                end else if (r_adel_pend) begin
                    w_out_valid = 1'b1;
                    w_out_adel  = 1'b1;
                    w_out_pc    = r_resp_pc;
                end
            end
        end
    endgenerate

    assign if_valid = w_out_valid;
    assign if_adel  = w_out_adel;
    assign if_pc    = w_out_pc;
    assign if_inst  = w_out_inst;

endmodule : if_fetch
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch
//  Description : Directed bench for if_fetch; a registered-ROM instance and a
//                combinational-ROM instance share one stimulus stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;

    logic        ce_r, ce_c;
    logic [31:0] addr_r, addr_c;
    logic [31:0] rom_r, rom_c;
    logic [31:0] pc_r, pc_c;
    logic [31:0] inst_r, inst_c;
    logic        valid_r, valid_c;
    logic        adel_r, adel_c;

    int checks = 0;
    int errors = 0;

    // ROM contents: word i holds 0x3401_0001 + i.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h3401_0001 + {24'h0, a[9:2]};
    endfunction

    if_fetch #(.REG_OUT(1)) dut_r (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .rom_ce(ce_r), .rom_addr(addr_r), .rom_inst(rom_r),
        .if_pc(pc_r), .if_inst(inst_r), .if_valid(valid_r), .if_adel(adel_r)
    );

    if_fetch #(.REG_OUT(0)) dut_c (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .rom_ce(ce_c), .rom_addr(addr_c), .rom_inst(rom_c),
        .if_pc(pc_c), .if_inst(inst_c), .if_valid(valid_c), .if_adel(adel_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM for the REG_OUT=1 instance.
    initial rom_r = 32'h0;
    always @(posedge clk) if (ce_r) rom_r <= rom_word(addr_r);

    // Combinational ROM for the REG_OUT=0 instance.
    assign rom_c = ce_c ? rom_word(addr_c) : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Registered instance: valid, pc, inst, adel, rom_ce.
    task automatic chk_r(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] inst, input logic adel, input logic ce);
        chk({tag, ".r.valid"}, {31'h0, valid_r}, {31'h0, v});
        chk({tag, ".r.pc"},    pc_r,   pc);
        chk({tag, ".r.inst"},  inst_r, inst);
        chk({tag, ".r.adel"},  {31'h0, adel_r}, {31'h0, adel});
        chk({tag, ".r.ce"},    {31'h0, ce_r},   {31'h0, ce});
    endtask

    // Combinational instance: pc/inst only meaningful when valid.
    task automatic chk_c(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] inst);
        chk({tag, ".c.valid"}, {31'h0, valid_c}, {31'h0, v});
        if (v) begin
            chk({tag, ".c.pc"},   pc_c,   pc);
            chk({tag, ".c.inst"}, inst_c, inst);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; new_pc = 32'h0;
        branch_flag = 1'b0; branch_target = 32'h0;
        tick(); tick();
        // Reset state, rst still high.
        #1;
        chk_r("reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk_c("reset", 1'b0, 32'h0, 32'h0);

        // c0: rst released, still IDLE.
        rst = 1'b0; #1;
        chk_r("c0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk_c("c0", 1'b0, 32'h0, 32'h0);

        // c1..c7: sequential run, branch to 0x40 while 0xC is being requested.
        tick(); #1;
        chk_r("c1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk_c("c1", 1'b1, 32'h0, 32'h3401_0001);
        tick(); #1;
        chk_r("c2", 1'b1, 32'h0, 32'h3401_0001, 1'b0, 1'b1);
        chk_c("c2", 1'b1, 32'h4, 32'h3401_0002);
        tick(); #1;
        chk_r("c3", 1'b1, 32'h4, 32'h3401_0002, 1'b0, 1'b1);
        chk_c("c3", 1'b1, 32'h8, 32'h3401_0003);
        tick(); branch_flag = 1'b1; branch_target = 32'h40; #1;
        chk_r("c4", 1'b1, 32'h8, 32'h3401_0003, 1'b0, 1'b1);
        chk_c("c4", 1'b1, 32'hC, 32'h3401_0004);
        tick(); branch_flag = 1'b0; #1;
        chk_r("c5_slot", 1'b1, 32'hC, 32'h3401_0004, 1'b0, 1'b1);
        chk_c("c5_tgt", 1'b1, 32'h40, 32'h3401_0011);
        tick(); #1;
        chk_r("c6_tgt", 1'b1, 32'h40, 32'h3401_0011, 1'b0, 1'b1);
        chk_c("c6", 1'b1, 32'h44, 32'h3401_0012);
        // c7: reset asserted while 0x48 is being requested.
        tick(); rst = 1'b1; #1;
        chk_r("c7", 1'b1, 32'h44, 32'h3401_0012, 1'b0, 1'b1);

        // c8: back in IDLE; request for 0x48 must never appear.
        tick(); rst = 1'b0; #1;
        chk_r("c8_rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk_c("c8_rst", 1'b0, 32'h0, 32'h0);
        tick(); #1;
        chk_r("c9_nopulse", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick(); #1;
        chk_r("c10", 1'b1, 32'h0, 32'h3401_0001, 1'b0, 1'b1);

        // c11..c13: stall while if_pc=4 is presented.
        tick(); stall = 1'b1; #1;
        chk_r("c11_stall", 1'b1, 32'h4, 32'h3401_0002, 1'b0, 1'b0);
        tick(); #1;
        chk_r("c12_stall", 1'b1, 32'h4, 32'h3401_0002, 1'b0, 1'b0);
        tick(); #1;
        chk_r("c13_stall", 1'b1, 32'h4, 32'h3401_0002, 1'b0, 1'b0);
        tick(); stall = 1'b0; #1;
        chk_r("c14_resume", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk(   "c14_addr", addr_r, 32'h8);
        tick(); #1;
        chk_r("c15", 1'b1, 32'h8, 32'h3401_0003, 1'b0, 1'b1);

        // c16: flush to 0x20 while 0x10 is being requested.
        tick(); flush = 1'b1; new_pc = 32'h20; #1;
        chk_r("c16", 1'b1, 32'hC, 32'h3401_0004, 1'b0, 1'b1);
        chk(   "c16_addr", addr_r, 32'h10);
        tick(); flush = 1'b0; #1;
        chk_r("c17_killed", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk(   "c17_addr", addr_r, 32'h20);

        // c18: branch to misaligned 0x42.
        tick(); branch_flag = 1'b1; branch_target = 32'h42; #1;
        chk_r("c18_flushtgt", 1'b1, 32'h20, 32'h3401_0009, 1'b0, 1'b1);
        tick(); branch_flag = 1'b0; #1;
        chk_r("c19", 1'b1, 32'h24, 32'h3401_000A, 1'b0, 1'b0);
        chk_c("c19", 1'b0, 32'h0, 32'h0);
        tick(); #1;
        chk_r("c20_adel", 1'b1, 32'h42, 32'h0, 1'b1, 1'b0);
        chk_c("c20_adel", 1'b1, 32'h42, 32'h0);
        chk(   "c20_adel.c", {31'h0, adel_c}, 32'h1);
        // c21: quiet, then flush to 0x80.
        tick(); flush = 1'b1; new_pc = 32'h80; #1;
        chk_r("c21_quiet", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick(); flush = 1'b0; #1;
        chk_r("c22", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk(   "c22_addr", addr_r, 32'h80);
        tick(); #1;
        chk_r("c23", 1'b1, 32'h80, 32'h3401_0021, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_if_fetch
`default_nettype wire
